// File: rtl/ci_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ci_master_arbiter
// Description : Round-robin arbiter that lets two common_interface masters
//               share one common_interface slave port. A grant is held from
//               command issue until the slave reports finish. The write/read
//               streams and the finish/status returns go only to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module ci_master_arbiter #(
    parameter int CSIZE = 4,
    parameter int LSIZE = 24,
    parameter int DSIZE = 32,
    parameter int ASIZE = 10
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clk_en,

    // master 0
    input  logic             m0_cmd_vld,
    input  logic [ASIZE-1:0] m0_addr,
    input  logic [LSIZE-1:0] m0_burst_len,
    input  logic [CSIZE-1:0] m0_cmd,
    output logic             m0_cmd_ready,
    output logic             m0_finish,
    output logic [3:0]       m0_status,
    input  logic             m0_wr_vld,
    input  logic [DSIZE-1:0] m0_wr_data,
    input  logic             m0_wr_last,
    output logic             m0_wr_ready,
    input  logic             m0_rd_ready,
    output logic             m0_rd_vld,
    output logic [DSIZE-1:0] m0_rd_data,
    output logic             m0_rd_last,

    // master 1
    input  logic             m1_cmd_vld,
    input  logic [ASIZE-1:0] m1_addr,
    input  logic [LSIZE-1:0] m1_burst_len,
    input  logic [CSIZE-1:0] m1_cmd,
    output logic             m1_cmd_ready,
    output logic             m1_finish,
    output logic [3:0]       m1_status,
    input  logic             m1_wr_vld,
    input  logic [DSIZE-1:0] m1_wr_data,
    input  logic             m1_wr_last,
    output logic             m1_wr_ready,
    input  logic             m1_rd_ready,
    output logic             m1_rd_vld,
    output logic [DSIZE-1:0] m1_rd_data,
    output logic             m1_rd_last,

    // slave
    output logic             s_cmd_vld,
    output logic [ASIZE-1:0] s_addr,
    output logic [LSIZE-1:0] s_burst_len,
    output logic [CSIZE-1:0] s_cmd,
    input  logic             s_cmd_ready,
    input  logic             s_finish,
    input  logic [3:0]       s_status,
    output logic             s_wr_vld,
    output logic [DSIZE-1:0] s_wr_data,
    output logic             s_wr_last,
    input  logic             s_wr_ready,
    output logic             s_rd_ready,
    input  logic             s_rd_vld,
    input  logic [DSIZE-1:0] s_rd_data,
    input  logic             s_rd_last,

    // status
    output logic             grant,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t     state_q,   state_d;
    logic       grant_q,   grant_d;
    logic       rr_ptr_q,  rr_ptr_d;
    logic [1:0] finish_q,  finish_d;
    logic [3:0] status0_q, status0_d;
    logic [3:0] status1_q, status1_d;

    logic             w_in_cmd;
    logic             w_in_xfer;
    logic             w_g_cmd_vld;
    logic [ASIZE-1:0] w_g_addr;
    logic [LSIZE-1:0] w_g_burst_len;
    logic [CSIZE-1:0] w_g_cmd;
    logic             w_g_wr_vld;
    logic [DSIZE-1:0] w_g_wr_data;
    logic             w_g_wr_last;
    logic             w_g_rd_ready;
    logic             w_own0;
    logic             w_own1;

    // Select the owning master's request and stream signals.
    always_comb begin
        w_in_cmd      = (state_q == ST_CMD);
        w_in_xfer     = (state_q == ST_XFER);
        w_g_cmd_vld   = grant_q ? m1_cmd_vld   : m0_cmd_vld;
        w_g_addr      = grant_q ? m1_addr      : m0_addr;
        w_g_burst_len = grant_q ? m1_burst_len : m0_burst_len;
        w_g_cmd       = grant_q ? m1_cmd       : m0_cmd;
        w_g_wr_vld    = grant_q ? m1_wr_vld    : m0_wr_vld;
        w_g_wr_data   = grant_q ? m1_wr_data   : m0_wr_data;
        w_g_wr_last   = grant_q ? m1_wr_last   : m0_wr_last;
        w_g_rd_ready  = grant_q ? m1_rd_ready  : m0_rd_ready;
        w_own0        = ~grant_q;
        w_own1        = grant_q;
    end

    // Next-state logic: arbitration, command handshake and finish capture.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        finish_d  = finish_q;
        status0_d = status0_q;
        status1_d = status1_q;

        if (clk_en) begin
            // finish is a single enabled-cycle pulse
            finish_d = 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (m0_cmd_vld && m1_cmd_vld) begin
                        grant_d = rr_ptr_q;
                        state_d = ST_CMD;
                    end else if (m0_cmd_vld) begin
                        grant_d = 1'b0;
                        state_d = ST_CMD;
                    end else if (m1_cmd_vld) begin
                        grant_d = 1'b1;
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (!w_g_cmd_vld) begin
                        // requester withdrew before acceptance
                        state_d = ST_IDLE;
                    end else if (s_cmd_ready) begin
                        if (s_finish) begin
                            // zero-length transaction completes on accept
                            finish_d[grant_q] = 1'b1;
                            if (grant_q) status1_d = s_status;
                            else         status0_d = s_status;
                            rr_ptr_d = ~grant_q;
                            state_d  = ST_IDLE;
                        end else begin
                            state_d = ST_XFER;
                        end
                    end
                end
                ST_XFER: begin
                    if (s_finish) begin
                        finish_d[grant_q] = 1'b1;
                        if (grant_q) status1_d = s_status;
                        else         status0_d = s_status;
                        rr_ptr_d = ~grant_q;
                        state_d  = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            rr_ptr_q  <= 1'b0;
            finish_q  <= 2'b00;
            status0_q <= 4'h0;
            status1_q <= 4'h0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            finish_q  <= finish_d;
            status0_q <= status0_d;
            status1_q <= status1_d;
        end
    end

    // Combinational routing between the owner and the slave.
    always_comb begin
        s_cmd_vld    = w_in_cmd & w_g_cmd_vld;
        s_addr       = w_in_cmd ? w_g_addr      : {ASIZE{1'b0}};
        s_burst_len  = w_in_cmd ? w_g_burst_len : {LSIZE{1'b0}};
        s_cmd        = w_in_cmd ? w_g_cmd       : {CSIZE{1'b0}};
        m0_cmd_ready = w_in_cmd & w_own0 & s_cmd_ready;
        m1_cmd_ready = w_in_cmd & w_own1 & s_cmd_ready;

        s_wr_vld     = w_in_xfer & w_g_wr_vld;
        s_wr_data    = w_in_xfer ? w_g_wr_data : {DSIZE{1'b0}};
        s_wr_last    = w_in_xfer & w_g_wr_last;
        m0_wr_ready  = w_in_xfer & w_own0 & s_wr_ready;
        m1_wr_ready  = w_in_xfer & w_own1 & s_wr_ready;

        s_rd_ready   = w_in_xfer & w_g_rd_ready;
        m0_rd_vld    = w_in_xfer & w_own0 & s_rd_vld;
        m1_rd_vld    = w_in_xfer & w_own1 & s_rd_vld;
        m0_rd_last   = w_in_xfer & w_own0 & s_rd_last;
        m1_rd_last   = w_in_xfer & w_own1 & s_rd_last;
        m0_rd_data   = (w_in_xfer & w_own0) ? s_rd_data : {DSIZE{1'b0}};
        m1_rd_data   = (w_in_xfer & w_own1) ? s_rd_data : {DSIZE{1'b0}};

        m0_finish    = finish_q[0];
        m1_finish    = finish_q[1];
        m0_status    = status0_q;
        m1_status    = status1_q;
        grant        = grant_q;
        busy         = (state_q != ST_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_ci_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ci_master_arbiter
// Description : Directed self-checking bench for ci_master_arbiter with a
//               transaction-level reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ci_master_arbiter;

    localparam int CSIZE = 4;
    localparam int LSIZE = 24;
    localparam int DSIZE = 32;
    localparam int ASIZE = 10;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    logic clk_en = 1'b1;

    logic             m_cmd_vld   [2];
    logic [ASIZE-1:0] m_addr      [2];
    logic [LSIZE-1:0] m_burst_len [2];
    logic [CSIZE-1:0] m_cmd       [2];
    logic             m_cmd_ready [2];
    logic             m_finish    [2];
    logic [3:0]       m_status    [2];
    logic             m_wr_vld    [2];
    logic [DSIZE-1:0] m_wr_data   [2];
    logic             m_wr_last   [2];
    logic             m_wr_ready  [2];
    logic             m_rd_ready  [2];
    logic             m_rd_vld    [2];
    logic [DSIZE-1:0] m_rd_data   [2];
    logic             m_rd_last   [2];

    logic             s_cmd_vld;
    logic [ASIZE-1:0] s_addr;
    logic [LSIZE-1:0] s_burst_len;
    logic [CSIZE-1:0] s_cmd;
    logic             s_cmd_ready;
    logic             s_finish;
    logic [3:0]       s_status;
    logic             s_wr_vld;
    logic [DSIZE-1:0] s_wr_data;
    logic             s_wr_last;
    logic             s_wr_ready;
    logic             s_rd_ready;
    logic             s_rd_vld;
    logic [DSIZE-1:0] s_rd_data;
    logic             s_rd_last;
    logic             grant;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    ci_master_arbiter #(.CSIZE(CSIZE), .LSIZE(LSIZE), .DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .clock(clock), .rst(rst), .clk_en(clk_en),
        .m0_cmd_vld(m_cmd_vld[0]), .m0_addr(m_addr[0]), .m0_burst_len(m_burst_len[0]),
        .m0_cmd(m_cmd[0]), .m0_cmd_ready(m_cmd_ready[0]), .m0_finish(m_finish[0]),
        .m0_status(m_status[0]), .m0_wr_vld(m_wr_vld[0]), .m0_wr_data(m_wr_data[0]),
        .m0_wr_last(m_wr_last[0]), .m0_wr_ready(m_wr_ready[0]), .m0_rd_ready(m_rd_ready[0]),
        .m0_rd_vld(m_rd_vld[0]), .m0_rd_data(m_rd_data[0]), .m0_rd_last(m_rd_last[0]),
        .m1_cmd_vld(m_cmd_vld[1]), .m1_addr(m_addr[1]), .m1_burst_len(m_burst_len[1]),
        .m1_cmd(m_cmd[1]), .m1_cmd_ready(m_cmd_ready[1]), .m1_finish(m_finish[1]),
        .m1_status(m_status[1]), .m1_wr_vld(m_wr_vld[1]), .m1_wr_data(m_wr_data[1]),
        .m1_wr_last(m_wr_last[1]), .m1_wr_ready(m_wr_ready[1]), .m1_rd_ready(m_rd_ready[1]),
        .m1_rd_vld(m_rd_vld[1]), .m1_rd_data(m_rd_data[1]), .m1_rd_last(m_rd_last[1]),
        .s_cmd_vld(s_cmd_vld), .s_addr(s_addr), .s_burst_len(s_burst_len), .s_cmd(s_cmd),
        .s_cmd_ready(s_cmd_ready), .s_finish(s_finish), .s_status(s_status),
        .s_wr_vld(s_wr_vld), .s_wr_data(s_wr_data), .s_wr_last(s_wr_last),
        .s_wr_ready(s_wr_ready), .s_rd_ready(s_rd_ready), .s_rd_vld(s_rd_vld),
        .s_rd_data(s_rd_data), .s_rd_last(s_rd_last),
        .grant(grant), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a transaction is either absent, requested (owned,
    // not yet accepted) or accepted; completion hands priority over.
    // ------------------------------------------------------------------
    bit       md_owned, md_owner, md_acc, md_rr, md_gv;
    bit [1:0] md_fin;
    bit [3:0] md_stat [2];

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            md_owned = 0; md_owner = 0; md_acc = 0; md_rr = 0; md_fin = 0;
            md_stat[0] = 0; md_stat[1] = 0;
        end else if (clk_en) begin
            md_gv  = m_cmd_vld[md_owner];
            md_fin = 0;
            if (!md_owned) begin
                if (m_cmd_vld[0] || m_cmd_vld[1]) begin
                    md_owner = (m_cmd_vld[0] && m_cmd_vld[1]) ? md_rr : m_cmd_vld[1];
                    md_owned = 1;
                    md_acc   = 0;
                end
            end else if ((!md_acc && md_gv && s_cmd_ready && s_finish) || (md_acc && s_finish)) begin
                md_fin[md_owner]  = 1;
                md_stat[md_owner] = s_status;
                md_rr    = ~md_owner;
                md_owned = 0;
            end else if (!md_acc) begin
                if (!md_gv)           md_owned = 0;
                else if (s_cmd_ready) md_acc   = 1;
            end
        end
    end

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clock) begin
        if (chk_on) begin
            bit cph, xph;
            int g;
            cph = md_owned && !md_acc;
            xph = md_owned && md_acc;
            g   = int'(md_owner);
            check("busy", busy, md_owned);
            if (md_owned) check("grant", grant, md_owner);
            check("s_cmd_vld", s_cmd_vld, cph && m_cmd_vld[g]);
            check("s_addr", s_addr, cph ? m_addr[g] : 0);
            check("s_burst_len", s_burst_len, cph ? m_burst_len[g] : 0);
            check("s_cmd", s_cmd, cph ? m_cmd[g] : 0);
            check("s_wr_vld", s_wr_vld, xph && m_wr_vld[g]);
            check("s_wr_data", s_wr_data, xph ? m_wr_data[g] : 0);
            check("s_wr_last", s_wr_last, xph && m_wr_last[g]);
            check("s_rd_ready", s_rd_ready, xph && m_rd_ready[g]);
            for (int n = 0; n < 2; n++) begin
                bit mine;
                mine = (g == n);
                check("cmd_ready", m_cmd_ready[n], cph && mine && s_cmd_ready);
                check("wr_ready", m_wr_ready[n], xph && mine && s_wr_ready);
                check("rd_vld", m_rd_vld[n], xph && mine && s_rd_vld);
                check("rd_last", m_rd_last[n], xph && mine && s_rd_last);
                check("rd_data", m_rd_data[n], (xph && mine) ? s_rd_data : 0);
                check("finish", m_finish[n], md_fin[n]);
                check("status", m_status[n], md_stat[n]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        for (int n = 0; n < 2; n++) begin
            m_cmd_vld[n] = 0; m_addr[n] = 0; m_burst_len[n] = 0; m_cmd[n] = 0;
            m_wr_vld[n] = 0; m_wr_data[n] = 0; m_wr_last[n] = 0; m_rd_ready[n] = 0;
        end
        s_cmd_ready = 0; s_finish = 0; s_status = 0; s_wr_ready = 0;
        s_rd_vld = 0; s_rd_data = 0; s_rd_last = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        clk_en = 1;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    // Wait (bounded) for a command to be presented to the slave.
    task automatic wait_cmd();
        bit ok;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (s_cmd_vld) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("cmd_timeout", ok, 1);
    endtask

    task automatic accept();
        s_cmd_ready = 1;
        tick();
        s_cmd_ready = 0;
        m_cmd_vld[0] = 0;
        m_cmd_vld[1] = 0;
    endtask

    int got [4];
    int beats;

    initial begin
        clear_inputs();
        #2;
        do_reset();
        chk_on = 1;
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_status0", m_status[0], 0);

        // ---- single write request from m0 ----
        m_cmd_vld[0] = 1; m_addr[0] = 10'h155; m_burst_len[0] = 4; m_cmd[0] = 2;
        #1 check("lat_before", s_cmd_vld, 0);
        tick();
        check("lat_one", s_cmd_vld, 1);
        check("s1_addr", s_addr, 10'h155);
        check("s1_len", s_burst_len, 4);
        tick();
        s_cmd_ready = 1;
        #1 check("s1_cmd_ready", m_cmd_ready[0], 1);
        accept();
        s_wr_ready = 1;
        for (int i = 0; i < 4; i++) begin
            m_wr_vld[0] = 1; m_wr_data[0] = 32'hD000_0000 + i; m_wr_last[0] = (i == 3);
            #1;
            check("s1_wr_data", s_wr_data, 32'hD000_0000 + i);
            check("s1_wr_last", s_wr_last, (i == 3));
            check("s1_wr_ready", m_wr_ready[0], 1);
            check("s1_m1_wr_ready", m_wr_ready[1], 0);
            tick();
        end
        m_wr_vld[0] = 0; m_wr_last[0] = 0; s_wr_ready = 0;
        s_finish = 1; s_status = 4'h3;
        tick();
        s_finish = 0;
        check("s1_finish", m_finish[0], 1);
        check("s1_status", m_status[0], 4'h3);
        check("s1_m1_finish", m_finish[1], 0);
        tick();
        check("s1_finish_pulse", m_finish[0], 0);
        check("s1_status_hold", m_status[0], 4'h3);

        // ---- simultaneous requests, zero-length transactions ----
        do_reset();
        m_cmd_vld[0] = 1; m_cmd_vld[1] = 1;
        for (int t = 0; t < 4; t++) begin
            tick();
            wait_cmd();
            got[t] = int'(grant);
            s_cmd_ready = 1; s_finish = 1; s_status = 4'(t + 8);
            tick();
            s_cmd_ready = 0; s_finish = 0;
            check("zl_finish", m_finish[got[t]], 1);
            check("zl_idle", busy, 0);
        end
        m_cmd_vld[0] = 0; m_cmd_vld[1] = 0;
        check("rr_order0", got[0], 0);
        check("rr_order1", got[1], 1);
        check("rr_order2", got[2], 0);
        check("rr_order3", got[3], 1);
        tick();
        check("rr_status0", m_status[0], 4'hA);
        check("rr_status1", m_status[1], 4'hB);

        // ---- read burst on m1 with toggling ready ----
        do_reset();
        m_cmd_vld[1] = 1; m_addr[1] = 10'h2AA; m_burst_len[1] = 3; m_cmd[1] = 1;
        tick();
        wait_cmd();
        check("rd_grant", grant, 1);
        accept();
        beats = 0;
        for (int c = 0; c < 20 && beats < 3; c++) begin
            m_rd_ready[1] = c[0];
            s_rd_vld = 1; s_rd_data = 32'hA0 + beats; s_rd_last = (beats == 2);
            #1;
            check("rd_mirror", s_rd_ready, m_rd_ready[1]);
            check("rd_m0_vld", m_rd_vld[0], 0);
            if (m_rd_vld[1] && m_rd_ready[1]) begin
                check("rd_data", m_rd_data[1], 32'hA0 + beats);
                check("rd_last", m_rd_last[1], (beats == 2));
                beats++;
            end
            tick();
        end
        check("rd_beats", beats, 3);
        s_rd_vld = 0; s_rd_last = 0; m_rd_ready[1] = 0;
        s_finish = 1; s_status = 4'h6;
        tick();
        s_finish = 0;
        check("rd_finish", m_finish[1], 1);
        check("rd_status", m_status[1], 4'h6);

        // ---- clk_en gating while the slave holds finish ----
        do_reset();
        m_cmd_vld[0] = 1; m_burst_len[0] = 2;
        tick();
        wait_cmd();
        accept();
        s_finish = 1; s_status = 4'h5; clk_en = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("gate_busy", busy, 1);
            check("gate_finish", m_finish[0], 0);
        end
        clk_en = 1;
        tick();
        s_finish = 0;
        check("gate_finish_after", m_finish[0], 1);
        check("gate_idle", busy, 0);
        check("gate_status", m_status[0], 4'h5);

        // ---- asynchronous reset in the middle of a write burst ----
        do_reset();
        m_cmd_vld[0] = 1; m_burst_len[0] = 4;
        tick();
        wait_cmd();
        accept();
        s_wr_ready = 1;
        for (int i = 0; i < 2; i++) begin
            m_wr_vld[0] = 1; m_wr_data[0] = 32'h100 + i;
            tick();
        end
        m_wr_data[0] = 32'h102;
        #1 check("mid_wr_vld", s_wr_vld, 1);
        rst = 1;
        #1;
        check("arst_wr_vld", s_wr_vld, 0);
        check("arst_busy", busy, 0);
        check("arst_wr_ready", m_wr_ready[0], 0);
        @(posedge clock);
        #1 rst = 0;
        clear_inputs();
        tick();
        check("arst_no_finish", m_finish[0], 0);
        m_cmd_vld[0] = 1; m_cmd_vld[1] = 1;
        tick();
        wait_cmd();
        check("arst_m0_wins", grant, 0);
        m_cmd_vld[0] = 0; m_cmd_vld[1] = 0;
        tick();
        tick();

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
